// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Program-counter / fetch stage placed directly upstream of instr_mem.
//   Drives the PC into the combinational ROM, captures the returned word into
//   an instruction register and presents it downstream with a valid flag.
//   Handles start, stall, taken branch (one-bubble squash) and halt detection.
//
// Ports
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   start          in   1      begin fetching at start_addr (honoured in IDLE/HALT)
//   start_addr     in   AW     first PC after start
//   stall          in   1      downstream not ready: hold all fetch state
//   branch_en      in   1      taken branch for the instruction in instr_out
//   branch_target  in   AW     absolute branch destination
//   instr_addr     out  AW     ROM address, combinational copy of the PC
//   instr_in       in   IW     ROM word for instr_addr, same cycle
//   instr_out      out  IW     registered instruction
//   pc_out         out  AW     address instr_out was fetched from
//   instr_valid    out  1      instr_out is live this cycle
//   done           out  1      halt word fetched; held until next start
//   fetch_cnt      out  CNT_W  saturating count of delivered instructions
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned     ROM_SIZE  = 256,
    parameter int unsigned     AW        = $clog2(ROM_SIZE) + 1,
    parameter int unsigned     IW        = $clog2(ROM_SIZE) + 1,
    parameter logic [IW-1:0]   HALT_WORD = {IW{1'b1}},
    parameter int unsigned     CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     start_addr,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [AW-1:0]     branch_target,
    output logic [AW-1:0]     instr_addr,
    input  logic [IW-1:0]     instr_in,
    output logic [IW-1:0]     instr_out,
    output logic [AW-1:0]     pc_out,
    output logic              instr_valid,
    output logic              done,
    output logic [CNT_W-1:0]  fetch_cnt
);

    localparam logic [AW-1:0] ROM_SIZE_A = AW'(ROM_SIZE);
    localparam logic [AW-1:0] PC_LAST    = AW'(ROM_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [IW-1:0]     instr_q, instr_d;
    logic [AW-1:0]     pc_out_q, pc_out_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Fold any externally supplied address into the ROM range.
    function automatic logic [AW-1:0] wrap_addr(input logic [AW-1:0] a);
        return a % ROM_SIZE_A;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        done_d   = done_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE, HALT: begin
                // Nothing is fetched here; the last delivered word stays visible but not valid.
                valid_d = 1'b0;
                if (start) begin
                    state_d = FETCH;
                    pc_d    = wrap_addr(start_addr);
                    done_d  = 1'b0;
                end
            end

            FETCH: begin
                // Stall outranks everything, including a pending branch.
                if (!stall) begin
                    if (branch_en && valid_q) begin
                        // Word at the current PC is wrong-path: drop it, redirect.
                        pc_d    = wrap_addr(branch_target);
                        valid_d = 1'b0;
                    end else begin
                        instr_d  = instr_in;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = (pc_q == PC_LAST) ? '0 : pc_q + AW'(1);
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        // Halt word is still delivered valid for this one cycle.
                        if (instr_in == HALT_WORD) begin
                            state_d = HALT;
                            done_d  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign instr_addr  = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign done        = done_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural ROM.
module tb_instr_fetch;

    localparam int unsigned AW    = 9;
    localparam int unsigned IW    = 9;
    localparam int unsigned CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [AW-1:0]     start_addr;
    logic              stall;
    logic              branch_en;
    logic [AW-1:0]     branch_target;
    logic [AW-1:0]     instr_addr;
    logic [IW-1:0]     instr_in;
    logic [IW-1:0]     instr_out;
    logic [AW-1:0]     pc_out;
    logic              instr_valid;
    logic              done;
    logic [CNT_W-1:0]  fetch_cnt;

    logic [IW-1:0]     rom [0:255];

    int total;
    int bad;

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .instr_addr    (instr_addr),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .done          (done),
        .fetch_cnt     (fetch_cnt)
    );

    assign instr_in = rom[instr_addr[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the four main delivery outputs at once.
    task automatic chk_out(input string tag, input logic v, input logic [AW-1:0] pc,
                           input logic [IW-1:0] ins, input logic [CNT_W-1:0] cnt);
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".pc_out"}, 32'(pc_out), 32'(pc));
        check({tag, ".instr"}, 32'(instr_out), 32'(ins));
        check({tag, ".cnt"}, 32'(fetch_cnt), 32'(cnt));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        start_addr = '0;
        stall = 1'b0;
        branch_en = 1'b0;
        branch_target = '0;
        for (int i = 0; i < 256; i++) rom[i] = IW'(i);
        rom[0] = 9'h001;
        rom[1] = 9'h002;
        rom[2] = 9'h003;
        rom[3] = 9'h1FF;
        rom[16] = 9'h1FF;
        rom[5] = 9'h055;

        // Reset state
        #3;
        chk_out("rst", 1'b0, 9'd0, 9'h000, 16'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.addr", 32'(instr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle.valid", 32'(instr_valid), 32'd0);

        // 1: basic run to halt
        start = 1'b1; start_addr = 9'd0;
        step();
        start = 1'b0;
        check("t1.start.valid", 32'(instr_valid), 32'd0);
        check("t1.start.addr", 32'(instr_addr), 32'd0);
        step(); chk_out("t1.c0", 1'b1, 9'd0, 9'h001, 16'd1);
        step(); chk_out("t1.c1", 1'b1, 9'd1, 9'h002, 16'd2);
        step(); chk_out("t1.c2", 1'b1, 9'd2, 9'h003, 16'd3);
        step(); chk_out("t1.c3", 1'b1, 9'd3, 9'h1FF, 16'd4);
        check("t1.done", 32'(done), 32'd1);
        step(); chk_out("t1.after", 1'b0, 9'd3, 9'h1FF, 16'd4);
        check("t1.done_hold", 32'(done), 32'd1);
        check("t1.pc_hold", 32'(instr_addr), 32'd4);
        step();
        check("t1.halt_valid", 32'(instr_valid), 32'd0);
        check("t1.halt_pc", 32'(instr_addr), 32'd4);

        // 2: stall for 3 cycles while instr_out=ROM[1]; branch during stall ignored
        start = 1'b1; start_addr = 9'd0;
        step();
        start = 1'b0;
        check("t2.done_clr", 32'(done), 32'd0);
        step(); chk_out("t2.c0", 1'b1, 9'd0, 9'h001, 16'd5);
        step(); chk_out("t2.c1", 1'b1, 9'd1, 9'h002, 16'd6);
        stall = 1'b1; branch_en = 1'b1; branch_target = 9'd16;
        step(); chk_out("t2.s0", 1'b1, 9'd1, 9'h002, 16'd6);
        branch_en = 1'b0;
        step(); chk_out("t2.s1", 1'b1, 9'd1, 9'h002, 16'd6);
        step(); chk_out("t2.s2", 1'b1, 9'd1, 9'h002, 16'd6);
        stall = 1'b0;
        step(); chk_out("t2.c2", 1'b1, 9'd2, 9'h003, 16'd7);
        step(); chk_out("t2.c3", 1'b1, 9'd3, 9'h1FF, 16'd8);
        check("t2.done", 32'(done), 32'd1);

        // 3: branch to 16 while pc_out=1
        start = 1'b1; start_addr = 9'd0;
        step();
        start = 1'b0;
        step(); chk_out("t3.c0", 1'b1, 9'd0, 9'h001, 16'd9);
        step(); chk_out("t3.c1", 1'b1, 9'd1, 9'h002, 16'd10);
        branch_en = 1'b1; branch_target = 9'd16;
        step();
        branch_en = 1'b0;
        check("t3.bubble", 32'(instr_valid), 32'd0);
        check("t3.bubble_cnt", 32'(fetch_cnt), 32'd10);
        check("t3.redirect", 32'(instr_addr), 32'd16);
        step(); chk_out("t3.tgt", 1'b1, 9'd16, 9'h1FF, 16'd11);
        check("t3.done", 32'(done), 32'd1);

        // 4: wrap 254,255,0,1; branch while not valid is ignored
        start = 1'b1; start_addr = 9'd254;
        step();
        start = 1'b0;
        check("t4.addr254", 32'(instr_addr), 32'd254);
        branch_en = 1'b1; branch_target = 9'd100;
        step(); chk_out("t4.c254", 1'b1, 9'd254, 9'h0FE, 16'd12);
        branch_en = 1'b0;
        check("t4.addr255", 32'(instr_addr), 32'd255);
        step(); chk_out("t4.c255", 1'b1, 9'd255, 9'h0FF, 16'd13);
        check("t4.addr_wrap", 32'(instr_addr), 32'd0);
        check("t4.msb0", 32'(instr_addr[8]), 32'd0);
        step(); chk_out("t4.c0", 1'b1, 9'd0, 9'h001, 16'd14);
        step(); chk_out("t4.c1", 1'b1, 9'd1, 9'h002, 16'd15);
        check("t4.msb1", 32'(instr_addr[8]), 32'd0);

        // 5: asynchronous reset mid-FETCH
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("t5.async", 1'b0, 9'd0, 9'h000, 16'd0);
        check("t5.addr", 32'(instr_addr), 32'd0);
        check("t5.done", 32'(done), 32'd0);
        start = 1'b1; start_addr = 9'd7;
        step();
        start = 1'b0;
        chk_out("t5.held", 1'b0, 9'd0, 9'h000, 16'd0);
        check("t5.held_addr", 32'(instr_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("t5.idle", 32'(instr_valid), 32'd0);
        check("t5.idle_addr", 32'(instr_addr), 32'd0);

        // 6: start during FETCH ignored; restart from HALT at 5
        start = 1'b1; start_addr = 9'd0;
        step();
        start = 1'b0;
        step(); chk_out("t6.c0", 1'b1, 9'd0, 9'h001, 16'd1);
        start = 1'b1; start_addr = 9'd5;
        step(); chk_out("t6.ign", 1'b1, 9'd1, 9'h002, 16'd2);
        start = 1'b0;
        step(); chk_out("t6.c2", 1'b1, 9'd2, 9'h003, 16'd3);
        step(); chk_out("t6.c3", 1'b1, 9'd3, 9'h1FF, 16'd4);
        check("t6.done", 32'(done), 32'd1);
        step();
        check("t6.halt", 32'(instr_valid), 32'd0);
        start = 1'b1; start_addr = 9'd5;
        step();
        start = 1'b0;
        check("t6.done_clr", 32'(done), 32'd0);
        check("t6.restart_valid", 32'(instr_valid), 32'd0);
        step(); chk_out("t6.c5", 1'b1, 9'd5, 9'h055, 16'd5);
        check("t6.done_low", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
